// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 19-bit CPU.
// Owns the PC, a return-address stack and the shared instruction/data memory port.
// Optional build macro SEQ_PERF_EN enables the retired-instruction counter
// (perf_retired); without it perf_retired is tied to zero.
module cpu_sequencer #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [18:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              zero_flag,
  output logic [18:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic              reg_we,
  output logic              wb_sel,
  output logic              mem_lat,
  output logic              halted,
  output logic [1:0]        fault,
  output logic [31:0]       perf_retired
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_BEQ  = 5'b11001;
  localparam logic [4:0] OP_BNE  = 5'b11010;
  localparam logic [4:0] OP_CALL = 5'b11011;
  localparam logic [4:0] OP_RET  = 5'b11100;
  localparam logic [4:0] OP_LD   = 5'b11101;
  localparam logic [4:0] OP_ST   = 5'b11110;

  localparam logic [1:0] FLT_ILLEGAL   = 2'd1;
  localparam logic [1:0] FLT_OVERFLOW  = 2'd2;
  localparam logic [1:0] FLT_UNDERFLOW = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_q;
  logic [18:0]       instr_q;
  logic [SP_W-1:0]   sp_q;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [1:0]        fault_q;
  logic [ADDR_W-1:0] daddr_q;

  logic [4:0]        opcode;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic              is_illegal, is_alu, is_ld, is_st, is_call, is_ret, is_ctrl;
  logic              stack_full, stack_empty;

  // Instruction field decode and stack status
  always_comb begin
    opcode      = instr_q[18:14];
    target      = instr_q[ADDR_W-1:0];
    pc_inc      = pc_q + ADDR_W'(1);
    is_illegal  = (opcode[4:2] == 3'b101) || (opcode == 5'b11111);
    is_alu      = !opcode[4] || (opcode[4:2] == 3'b100);
    is_ld       = (opcode == OP_LD);
    is_st       = (opcode == OP_ST);
    is_call     = (opcode == OP_CALL);
    is_ret      = (opcode == OP_RET);
    is_ctrl     = (opcode == OP_JMP) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                  is_call || is_ret;
    stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    stack_empty = (sp_q == '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = is_illegal ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (is_alu)                      state_nxt = S_WB;
        else if (is_ld || is_st)         state_nxt = S_MEM;
        else if (is_call && stack_full)  state_nxt = S_HALT;
        else if (is_ret && stack_empty)  state_nxt = S_HALT;
        else                             state_nxt = S_FETCH;
      end
      S_MEM:    if (mem_ready) state_nxt = is_ld ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Output decode; mem_req is gated by rst_n so a reset abandons any access at once
  always_comb begin
    mem_req  = rst_n && ((state == S_FETCH) || (state == S_MEM));
    mem_we   = (state == S_MEM) && is_st;
    mem_addr = (state == S_MEM) ? daddr_q : pc_q;
    reg_we   = (state == S_WB);
    wb_sel   = (state == S_WB) && is_ld;
    mem_lat  = (state == S_MEM) && is_ld && mem_ready;
    halted   = (state == S_HALT);
    instr    = instr_q;
    pc       = pc_q;
    fault    = fault_q;
  end

  // PC, instruction register, return stack, fault cause and latched data address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= '0;
      sp_q    <= '0;
      fault_q <= '0;
      daddr_q <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) instr_q <= mem_rdata;
        S_DECODE: if (is_illegal) fault_q <= FLT_ILLEGAL;
        S_EXEC: begin
          if (is_ld || is_st) daddr_q <= data_addr;
          case (opcode)
            OP_JMP: pc_q <= target;
            OP_BEQ: pc_q <= zero_flag ? target : pc_inc;
            OP_BNE: pc_q <= !zero_flag ? target : pc_inc;
            OP_CALL: begin
              if (stack_full) begin
                fault_q <= FLT_OVERFLOW;
              end else begin
                stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
                sp_q                     <= sp_q + SP_W'(1);
                pc_q                     <= target;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                fault_q <= FLT_UNDERFLOW;
              end else begin
                pc_q <= stack_q[IDX_W'(sp_q - SP_W'(1))];
                sp_q <= sp_q - SP_W'(1);
              end
            end
            default: ;
          endcase
        end
        S_MEM: if (mem_ready && is_st) pc_q <= pc_inc;
        S_WB:  pc_q <= pc_inc;
        default: ;
      endcase
    end
  end

`ifdef SEQ_PERF_EN
  logic        retire;
  logic [31:0] perf_q;

  // Retire points: WB for ALU/LD, EXEC for non-faulting control flow, MEM-ready for ST
  always_comb begin
    retire = (state == S_WB) ||
             ((state == S_EXEC) && is_ctrl &&
              !(is_call && stack_full) && !(is_ret && stack_empty)) ||
             ((state == S_MEM) && is_st && mem_ready);
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      perf_q <= '0;
    else if (retire) perf_q <= perf_q + 32'd1;
  end

  assign perf_retired = perf_q;
`else
  assign perf_retired = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: instruction-level reference model plus per-cycle bus checker
// for cpu_sequencer, driven by directed programs.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ready, mem_lat;
  logic [13:0] mem_addr, data_addr, pc;
  logic [18:0] mem_rdata, instr;
  logic        zero_flag, reg_we, wb_sel, halted;
  logic [1:0]  fault;
  logic [31:0] perf_retired;

  always #5 clk = ~clk;

  cpu_sequencer #(.ADDR_W(14), .STACK_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .data_addr(data_addr), .zero_flag(zero_flag),
    .instr(instr), .pc(pc), .reg_we(reg_we), .wb_sel(wb_sel),
    .mem_lat(mem_lat), .halted(halted), .fault(fault),
    .perf_retired(perf_retired)
  );

  typedef struct packed {
    logic [1:0]  kind;   // 0 fetch, 1 load, 2 store
    logic [13:0] addr;
  } acc_t;

  logic [18:0] mem [16384];
  int          lat;
  int          wait_cnt;
  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 1'b0;

  acc_t        exp_acc[$];
  bit          exp_wb[$];
  logic [13:0] m_pc;
  logic [1:0]  m_fault;
  logic [18:0] m_instr;
  int          m_ret;

  int          cyc, lat_cnt, lat_cyc, ldwb_cnt, ldwb_cyc, daddr_cyc;

  localparam logic [18:0] ILLEGAL = {5'b11111, 14'h0};

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  function automatic logic [18:0] enc(input logic [4:0] op, input logic [13:0] t);
    return {op, t};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16384; i++) mem[i] = ILLEGAL;
  endtask

  // Instruction-set level model: walks the program and lists the bus/writeback events it implies
  task automatic model_run(input bit zf, input logic [13:0] da);
    logic [13:0] stk[$];
    logic [13:0] p;
    logic [18:0] w;
    logic [4:0]  op;
    bit          done;
    exp_acc.delete();
    exp_wb.delete();
    p = '0; m_fault = 2'd0; m_ret = 0; done = 1'b0; m_instr = '0;
    for (int n = 0; n < 500 && !done; n++) begin
      exp_acc.push_back('{2'd0, p});
      w = mem[p];
      m_instr = w;
      op = w[18:14];
      if (op inside {[5'd20:5'd23], 5'd31}) begin
        m_fault = 2'd1; done = 1'b1;
      end else if (op < 5'd20) begin
        exp_wb.push_back(1'b0); p = p + 14'd1; m_ret++;
      end else begin
        case (op)
          5'd24: begin p = w[13:0]; m_ret++; end
          5'd25: begin p = zf ? w[13:0] : p + 14'd1; m_ret++; end
          5'd26: begin p = !zf ? w[13:0] : p + 14'd1; m_ret++; end
          5'd27: begin
            if (stk.size() == 8) begin m_fault = 2'd2; done = 1'b1; end
            else begin stk.push_back(p + 14'd1); p = w[13:0]; m_ret++; end
          end
          5'd28: begin
            if (stk.size() == 0) begin m_fault = 2'd3; done = 1'b1; end
            else begin p = stk.pop_back(); m_ret++; end
          end
          5'd29: begin
            exp_acc.push_back('{2'd1, da}); exp_wb.push_back(1'b1); p = p + 14'd1; m_ret++;
          end
          default: begin
            exp_acc.push_back('{2'd2, da}); p = p + 14'd1; m_ret++;
          end
        endcase
      end
    end
    m_pc = p;
  endtask

  // Memory responder: answers a request after 'lat' wait cycles, inputs change on the falling edge
  initial begin
    mem_ready = 1'b0; mem_rdata = '0; wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wait_cnt = 0; mem_ready = 1'b0;
      end else begin
        if (mem_ready) wait_cnt = 0;
        mem_ready = 1'b0;
        if (mem_req) begin
          if (wait_cnt >= lat) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr];
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // Per-cycle comparison of bus activity and writebacks against the model's event lists
  initial begin
    bit          prev_wait;
    logic [14:0] prev_acc;
    acc_t        e;
    bit          wexp;
    prev_wait = 1'b0; prev_acc = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (chk_en) begin
        if (mem_req && mem_ready) begin
          check("acc_avail", 64'(exp_acc.size() != 0), 64'd1);
          if (exp_acc.size() != 0) begin
            e = exp_acc.pop_front();
            check("access", {mem_lat, mem_we, mem_addr},
                  {(e.kind == 2'd1), (e.kind == 2'd2), e.addr});
          end
          if (mem_addr == 14'h123) daddr_cyc++;
        end else begin
          check("lat_idle", 64'(mem_lat), 64'd0);
          if (mem_req && mem_addr == 14'h123) daddr_cyc++;
        end
        if (mem_lat) begin lat_cnt++; lat_cyc = cyc; end
        if (reg_we) begin
          check("wb_avail", 64'(exp_wb.size() != 0), 64'd1);
          if (exp_wb.size() != 0) begin
            wexp = exp_wb.pop_front();
            check("wb_sel", 64'(wb_sel), 64'(wexp));
            if (wb_sel) begin ldwb_cnt++; ldwb_cyc = cyc; end
          end
        end
        if (prev_wait && mem_req) check("hold", {mem_we, mem_addr}, prev_acc);
        if (halted) check("halt_quiet", {mem_req, reg_we}, 64'd0);
`ifndef SEQ_PERF_EN
        check("perf_zero", perf_retired, 64'd0);
`endif
      end
      prev_wait = chk_en && rst_n && mem_req && !mem_ready;
      prev_acc  = {mem_we, mem_addr};
    end
  end

  task automatic start_prog(input bit zf, input logic [13:0] da, input int l);
    chk_en = 1'b0;
    rst_n = 1'b0;
    zero_flag = zf; data_addr = da; lat = l;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pc_instr", {pc, instr}, 64'd0);
    check("rst_strobes", {mem_req, mem_we, mem_addr, reg_we, mem_lat, halted, fault}, 64'd0);
    check("rst_perf", perf_retired, 64'd0);
    model_run(zf, da);
    lat_cnt = 0; ldwb_cnt = 0; daddr_cyc = 0; lat_cyc = 0; ldwb_cyc = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic finish_prog(input string nm, input logic [13:0] lpc, input logic [1:0] lf, input int lret);
    logic [31:0] exp_perf;
    for (int i = 0; i < 3000 && !halted; i++) begin
      @(negedge clk);
      #1;
    end
    check({nm, ":halt_reached"}, 64'(halted), 64'd1);
    repeat (4) @(negedge clk);
    #1;
`ifdef SEQ_PERF_EN
    exp_perf = 32'(m_ret);
`else
    exp_perf = 32'd0;
`endif
    check({nm, ":pc"}, pc, m_pc);
    check({nm, ":fault"}, fault, m_fault);
    check({nm, ":instr"}, instr, m_instr);
    check({nm, ":perf"}, perf_retired, exp_perf);
    check({nm, ":acc_left"}, 64'(exp_acc.size()), 64'd0);
    check({nm, ":wb_left"}, 64'(exp_wb.size()), 64'd0);
    check({nm, ":model_pc"}, m_pc, lpc);
    check({nm, ":model_fault"}, m_fault, lf);
    check({nm, ":model_ret"}, 64'(m_ret), 64'(lret));
    chk_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; zero_flag = 1'b0; data_addr = '0; lat = 0; cyc = 0;

    // ALU at 0, zero-wait: exact cycle timing
    clear_mem();
    mem[0] = enc(5'b00001, 14'h0);
    start_prog(1'b0, 14'h0, 0);
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      #1;
      if (c == 0) check("t1_c0_req", {mem_req, mem_addr}, {1'b1, 14'h0});
      if (c == 2) check("t1_c2_noreg", 64'(reg_we), 64'd0);
      if (c == 3) check("t1_c3_wb", {reg_we, wb_sel}, 64'b10);
      if (c == 4) check("t1_c4_pc", pc, 64'd1);
    end
    finish_prog("alu", 14'd1, 2'd1, 1);

    // Reset during a pending fetch drops the request immediately
    start_prog(1'b0, 14'h0, 50);
    repeat (3) @(negedge clk);
    #1;
    check("pend_req", 64'(mem_req), 64'd1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_drop", {mem_req, pc}, 64'd0);

    // JMP chain then BEQ not taken / taken
    clear_mem();
    mem[0]     = enc(5'b11000, 14'h5);
    mem[5]     = enc(5'b11000, 14'h40);
    mem[14'h40] = enc(5'b11001, 14'h100);
    start_prog(1'b0, 14'h0, 0);
    finish_prog("beq_nt", 14'h41, 2'd1, 3);
    start_prog(1'b1, 14'h0, 0);
    finish_prog("beq_t", 14'h100, 2'd1, 3);

    // LD at pc=2 with three wait cycles on every access
    clear_mem();
    mem[0] = enc(5'b00010, 14'h0);
    mem[1] = enc(5'b00011, 14'h0);
    mem[2] = enc(5'b11101, 14'h0);
    mem[14'h123] = 19'h1abcd;
    start_prog(1'b0, 14'h123, 3);
    finish_prog("ld", 14'd3, 2'd1, 3);
    check("ld_lat_cnt", 64'(lat_cnt), 64'd1);
    check("ld_wb_cnt", 64'(ldwb_cnt), 64'd1);
    check("ld_wb_after_lat", 64'(ldwb_cyc), 64'(lat_cyc + 1));
    check("ld_addr_cycles", 64'(daddr_cyc), 64'd4);

    // Nine nested CALLs overflow the 8-entry stack
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = enc(5'b11011, 14'(i + 1));
    start_prog(1'b0, 14'h0, 0);
    finish_prog("call_ovf", 14'd8, 2'd2, 8);

    // Eight CALL / eight RET, then a RET on the empty stack
    clear_mem();
    mem[0] = enc(5'b11011, 14'h10);
    for (int k = 1; k < 8; k++) mem[16 * k] = enc(5'b11011, 14'(16 * (k + 1)));
    mem[14'h80] = enc(5'b11100, 14'h0);
    for (int k = 1; k < 8; k++) mem[16 * k + 1] = enc(5'b11100, 14'h0);
    mem[1] = enc(5'b11100, 14'h0);
    start_prog(1'b0, 14'h0, 0);
    finish_prog("call_ret", 14'd1, 2'd3, 16);

    // Illegal opcode 10101, then a reset pulse clears the fault
    clear_mem();
    mem[0] = enc(5'b10101, 14'h0);
    start_prog(1'b0, 14'h0, 0);
    finish_prog("illegal", 14'd0, 2'd1, 0);
    check("ill_sticky", {halted, fault}, {1'b1, 2'd1});
    rst_n = 1'b0;
    #1;
    check("ill_cleared", {halted, fault, pc}, 64'd0);

    // Ten mixed instructions including one ST, one-cycle memory latency
    clear_mem();
    mem[0]  = enc(5'b00011, 14'h0);
    mem[1]  = enc(5'b11000, 14'd4);
    mem[4]  = enc(5'b11010, 14'd8);
    mem[8]  = enc(5'b11101, 14'h0);
    mem[9]  = enc(5'b11110, 14'h0);
    mem[10] = enc(5'b11011, 14'd20);
    mem[20] = enc(5'b00111, 14'h0);
    mem[21] = enc(5'b11100, 14'h0);
    mem[11] = enc(5'b11001, 14'd30);
    mem[12] = enc(5'b10011, 14'h0);
    start_prog(1'b0, 14'h200, 1);
    finish_prog("mixed", 14'd13, 2'd1, 10);

    // PC wrap at the top of the address space
    clear_mem();
    mem[0]       = enc(5'b11011, 14'h3ffe);
    mem[14'h3ffe] = enc(5'b00001, 14'h0);
    mem[14'h3fff] = enc(5'b00001, 14'h0);
    start_prog(1'b0, 14'h0, 0);
    finish_prog("wrap", 14'd0, 2'd2, 24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle instruction sequencer for the 19-bit CPU. It owns the PC, a hardware return-address stack and the single shared memory port, which is time-shared between instruction fetch and LD/ST data access. It walks each 5-bit opcode through FETCH/DECODE/EXEC/MEM/WB and issues one-cycle register-write strobes to the register file/ALU datapath.

Parameters:
ADDR_W, 14, PC/memory address width (must be ≤14; branch/call target = instr[ADDR_W-1:0])
STACK_DEPTH, 8, return-address stack entries (power of 2, ≥2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_req  out  1  memory access request
mem_we  out  1  1=write (ST), 0=read
mem_addr  out  ADDR_W  access address
mem_rdata  in  19  read data
mem_ready  in  1  access complete this cycle (may be high in same cycle as mem_req)
data_addr  in  ADDR_W  LD/ST effective address from datapath
zero_flag  in  1  ALU zero flag, valid in EXEC
instr  out  19  instruction register
pc  out  ADDR_W  current program counter
reg_we  out  1  one-cycle register-file write strobe
wb_sel  out  1  0=ALU result, 1=mem_rdata (valid while reg_we=1)
mem_lat  out  1  pulse: load data accepted (datapath captures mem_rdata)
halted  out  1  sticky; sequencer stopped
fault  out  2  sticky cause: 0 none, 1 illegal opcode, 2 stack overflow, 3 stack underflow
perf_retired  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Opcode = instr[18:14]. ALU 00000–10011; JMP 11000; BEQ 11001; BNE 11010; CALL 11011; RET 11100; LD 11101; ST 11110; 10100–10111 and 11111 illegal.
- Reset (async, rst_n low): state=FETCH, pc=0, instr=0, stack pointer=0, stack contents=0, all strobes 0, mem_addr=0, halted=0, fault=0, perf_retired=0. Reset asserted mid-handshake drops mem_req immediately; the outstanding access is abandoned.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold until mem_ready; on mem_ready: instr<=mem_rdata, -> DECODE.
- DECODE (1 cycle): illegal -> fault=1, -> HALT. Otherwise -> EXEC.
- EXEC (1 cycle):
  - ALU -> WB.
  - JMP: pc<=target.
  - BEQ: pc<=zero_flag ? target : pc+1.
  - BNE: pc<=!zero_flag ? target : pc+1.
  - CALL: if stack full, fault=2 -> HALT. Otherwise push pc+1, pc<=target.
  - RET: if stack empty, fault=3 -> HALT. Otherwise pop into pc.
  - Control-flow ops -> FETCH; no reg_we.
  - LD/ST -> MEM.
- MEM: mem_req=1, mem_addr=data_addr, mem_we=(ST). Hold until mem_ready.
  - LD: mem_lat=1 on the ready cycle -> WB.
  - ST: pc<=pc+1 -> FETCH.
- WB (1 cycle): reg_we=1, wb_sel=(LD), pc<=pc+1 -> FETCH.
- HALT: terminal until reset. mem_req=0, reg_we=0, halted=1; pc and instr frozen.
- mem_addr/mem_we are held stable while mem_req=1 and mem_ready=0. mem_req is 0 in DECODE/EXEC/WB.
- Zero-wait latency: ALU and LD 4–5 cycles (FETCH, DECODE, EXEC, [MEM,] WB); control flow 3; ST 4.
- pc+1 and targets wrap modulo 2^ADDR_W (pc=2^ADDR_W-1 + 1 -> 0).
- Stack: full = STACK_DEPTH entries held; push and pop never coincide (one per instruction).
- Retire point: WB for ALU/LD, EXEC for control flow, MEM-ready for ST. Faulting instructions do not retire.

Optional Feature:
SEQ_PERF_EN
- Defined: perf_retired increments by 1 at each retire point and wraps at 2^32.
- Undefined: perf_retired is tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset, then memory[0]=ALU opcode 00001, zero-wait -> mem_req high cycle 0; reg_we pulses cycle 3 with wb_sel=0; pc=1 cycle 4.
- JMP to 0x0040 at pc=5, then BEQ to 0x0100 with zero_flag=0 -> pc 5→0x40→0x41. Repeat with zero_flag=1 -> pc=0x100.
- LD at pc=2, data_addr=0x123, mem_ready delayed 3 cycles -> mem_addr held at 0x123 during the wait; mem_lat and then reg_we with wb_sel=1; pc=3.
- Nested CALL 9 times with STACK_DEPTH=8 -> 9th CALL gives fault=2, halted=1, mem_req stays 0. A separate run of 8 CALL/8 RET returns to each caller's pc+1.
- Opcode 10101 fetched -> fault=1, halted=1 after DECODE; rst_n pulse clears to pc=0 and fault=0.
- SEQ_PERF_EN defined, run 10 mixed instructions including one ST -> perf_retired=10. Undefined -> perf_retired=0 throughout.
